// File: rtl/lutnet_table_loader.sv
// Runtime-loadable LUT neuron: accepts the truth table as a stream of config words,
// then serves registered single-cycle lookups once the full table has been framed correctly.
module lutnet_table_loader #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 1,
  parameter int unsigned CFG_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_last,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                table_valid,
  output logic                cfg_err
);

  localparam int unsigned Depth  = 2 ** IN_BITS;
  localparam int unsigned Epw    = CFG_W / OUT_BITS;
  localparam int unsigned NWords = Depth / Epw;
  localparam int unsigned CntW   = (NWords > 1) ? $clog2(NWords) : 1;
  localparam logic [CntW-1:0] LastWord = CntW'(NWords - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StActive, StErr} state_e;

  state_e                     state_q;
  logic [CntW-1:0]            cnt_q;
  logic [Depth*OUT_BITS-1:0]  tbl_q;
  logic                       accept;
  logic [OUT_BITS-1:0]        rd_data;

  // cfg_ready is a registered copy of (state == LOAD), so it doubles as the load qualifier.
  assign accept  = cfg_valid & cfg_ready & ~cfg_start;
  assign rd_data = tbl_q[in_data * OUT_BITS +: OUT_BITS];

  // Table storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      tbl_q[cnt_q * CFG_W +: CFG_W] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cfg_ready   <= 1'b0;
      table_valid <= 1'b0;
      cfg_err     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && (state_q == StActive) && !cfg_start) begin
        out_valid <= 1'b1;
        out_data  <= rd_data;
      end

      if (cfg_start) begin
        state_q     <= StLoad;
        cnt_q       <= '0;
        cfg_ready   <= 1'b1;
        table_valid <= 1'b0;
        cfg_err     <= 1'b0;
      end else begin
        unique case (state_q)
          StLoad: begin
            if (accept) begin
              if (cnt_q == LastWord && cfg_last) begin
                state_q     <= StActive;
                cfg_ready   <= 1'b0;
                table_valid <= 1'b1;
              end else if (cnt_q == LastWord || cfg_last) begin
                // Framing error: short table or missing terminator.
                state_q   <= StErr;
                cfg_ready <= 1'b0;
                cfg_err   <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lutnet_table_loader.sv
// Directed-sequence bench with random table contents; expected lookups come from a
// word-array model of the table indexed by plain division/modulo.
module tb_lutnet_table_loader;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [0:0]  out_data;
  logic        table_valid;
  logic        cfg_err;

  int          tests;
  int          fails;
  logic [31:0] ref_words[8];
  int          ref_k;

  lutnet_table_loader #(
    .IN_BITS (8),
    .OUT_BITS(1),
    .CFG_W   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .table_valid(table_valid),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_bit(input int idx);
    logic [31:0] w;
    w = ref_words[idx / 32];
    return w[idx % 32];
  endfunction

  task automatic do_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    ref_k     = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    tick();
    ref_words[ref_k] = d;
    ref_k++;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = '0;
  endtask

  // Full 8-word load with random lookups held on in_valid, which must all be dropped.
  task automatic full_load(input bit fixed0);
    logic [31:0] w;
    for (int k = 0; k < 8; k++) begin
      w        = (k == 0 && fixed0) ? 32'hFFFF0000 : $urandom;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      send_word(w, k == 7);
      check("lookup_dropped_in_load", out_valid, 0);
      if (k < 7) check("tv_low_during_load", table_valid, 0);
    end
    in_valid = 1'b0;
    check("tv_after_load", table_valid, 1);
    check("ready_low_after_load", cfg_ready, 0);
    check("err_low_after_load", cfg_err, 0);
  endtask

  task automatic lookup_check(input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx      = $urandom_range(0, 255);
      in_valid = 1'b1;
      in_data  = 8'(idx);
      tick();
      check("rand_lookup_valid", out_valid, 1);
      check("rand_lookup_data", out_data, ref_bit(idx));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    ref_k     = 0;
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    tick();
    tick();
    check("rst_ready", cfg_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_tv", table_valid, 0);
    check("rst_err", cfg_err, 0);
    rst = 1'b0;

    // 1: lookups with no table are dropped
    in_valid = 1'b1;
    in_data  = 8'h50;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_out_valid", out_valid, 0);
      check("idle_ready", cfg_ready, 0);
      check("idle_tv", table_valid, 0);
    end
    in_valid = 1'b0;

    // 2: first load, word 0 fixed so entry 0x10 is known to be 1
    do_start();
    check("load_ready", cfg_ready, 1);
    full_load(1'b1);
    in_valid = 1'b1;
    in_data  = 8'h10;
    tick();
    in_valid = 1'b0;
    check("lookup10_valid", out_valid, 1);
    check("lookup10_data", out_data, 1);

    // 3: sweep every index back to back
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      check("sweep_valid", out_valid, 1);
      check("sweep_data", out_data, ref_bit(i));
    end
    in_valid = 1'b0;
    tick();
    check("sweep_end_valid", out_valid, 0);
    check("sweep_hold_data", out_data, ref_bit(255));
    // config words offered in ACTIVE must not touch the table
    cfg_valid = 1'b1;
    cfg_data  = $urandom;
    cfg_last  = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    check("active_ready", cfg_ready, 0);
    check("active_tv", table_valid, 1);
    lookup_check(16);

    // 4: start kills a coincident lookup, then short table -> error
    in_valid  = 1'b1;
    in_data   = 8'h10;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    ref_k     = 0;
    check("start_kills_lookup", out_valid, 0);
    check("start_clears_tv", table_valid, 0);
    for (int k = 0; k < 4; k++) send_word($urandom, k == 3);
    check("short_err", cfg_err, 1);
    check("short_tv", table_valid, 0);
    check("short_ready", cfg_ready, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("err_lookup_dropped", out_valid, 0);
    check("err_sticky", cfg_err, 1);
    do_start();
    check("restart_clears_err", cfg_err, 0);
    full_load(1'b0);
    lookup_check(20);

    // 5: missing terminator -> error; then a load with a 5-cycle stall
    do_start();
    for (int k = 0; k < 8; k++) send_word($urandom, 1'b0);
    check("noterm_err", cfg_err, 1);
    check("noterm_tv", table_valid, 0);
    do_start();
    for (int k = 0; k < 4; k++) send_word($urandom, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ready", cfg_ready, 1);
      check("stall_tv", table_valid, 0);
      check("stall_err", cfg_err, 0);
    end
    for (int k = 4; k < 8; k++) send_word($urandom, k == 7);
    check("stall_load_tv", table_valid, 1);
    check("stall_load_err", cfg_err, 0);
    lookup_check(20);

    // 6: asynchronous reset mid-load
    do_start();
    for (int k = 0; k < 4; k++) send_word($urandom, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_ready", cfg_ready, 0);
    check("async_rst_tv", table_valid, 0);
    check("async_rst_err", cfg_err, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_lookup_dropped", out_valid, 0);
    check("post_rst_ready", cfg_ready, 0);
    // start with a coincident word mid-load: word discarded, counter back to 0
    do_start();
    for (int k = 0; k < 2; k++) send_word($urandom, 1'b0);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = $urandom;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    ref_k     = 0;
    check("start_word_ready", cfg_ready, 1);
    full_load(1'b0);
    lookup_check(24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
